// File: rtl/fifo_wr_arb_pkg.sv
// rtl/fifo_wr_arb_pkg.sv - shared state encoding and default sizing for fifo_wr_arb
package fifo_wr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_DW        = 32;
    localparam int DEF_DEPTH     = 1024;
    localparam int DEF_MAX_BURST = 16;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// rtl/fifo_wr_arb_rr_pick.sv - combinational rotate-priority pick: first valid index at or after ptr
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    logic [IW-1:0] cand;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        cand     = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(i_ptr) + i) % NREQ);
            if (!o_any && i_valid[cand]) begin
                o_any          = 1'b1;
                o_idx          = cand;
                o_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - packet-locking round-robin write arbiter in front of a fifo_sync
// FIFO_WR_ARB_CNT_EN adds per-requester accepted-word counters on o_beat_cnt.
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int DW        = DEF_DW,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NREQ-1:0]        i_req_valid,
    input  logic [NREQ-1:0]        i_req_last,
    input  logic [NREQ*DW-1:0]     i_req_data,
    output logic [NREQ-1:0]        o_req_ready,
    output logic                   o_wr,
    output logic [DW-1:0]          o_data,
    input  logic                   i_full,
    input  logic [$clog2(DEPTH):0] i_fill,
    output logic [NREQ-1:0]        o_grant,
    output logic                   o_busy
`ifdef FIFO_WR_ARB_CNT_EN
    ,
    output logic [NREQ*32-1:0]     o_beat_cnt
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int FW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [DW-1:0]   data_q, data_d;

    logic            space;
    logic            accept;
    logic            burst_end;
    logic [NREQ-1:0] pick_valid;
    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            sel_last;
    logic [DW-1:0]   sel_data;
    logic [CW-1:0]   cnt_inc;

    // The write registered last cycle has not reached i_fill yet, so count it here.
    assign space = !i_full &&
                   (({1'b0, i_fill} + (FW+1)'(wr_q)) < (FW+1)'(DEPTH));

    // While locked only the owner may compete; the pick then degenerates to that owner.
    assign pick_valid = (state_q == LOCK) ? (i_req_valid & grant_q) : i_req_valid;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .i_valid  (pick_valid),
        .i_ptr    (ptr_q),
        .o_onehot (pick_onehot),
        .o_idx    (pick_idx),
        .o_any    (pick_any)
    );

    assign accept = space && pick_any && !i_rst;

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick_onehot[k]) begin
                sel_data = i_req_data[k*DW +: DW];
            end
        end
    end

    assign sel_last  = |(i_req_last & pick_onehot);
    assign cnt_inc   = (state_q == LOCK) ? (cnt_q + 1'b1) : CW'(1);
    assign burst_end = sel_last || (cnt_inc == CW'(MAX_BURST));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        data_d  = data_q;
        if (accept) begin
            wr_d   = 1'b1;
            data_d = sel_data;
            if (burst_end) begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
                ptr_d   = (pick_idx == IW'(NREQ - 1)) ? '0 : (pick_idx + 1'b1);
            end else begin
                state_d = LOCK;
                grant_d = pick_onehot;
                cnt_d   = cnt_inc;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
        end
    end

    assign o_req_ready = accept ? pick_onehot : '0;
    assign o_wr        = wr_q;
    assign o_data      = data_q;
    assign o_grant     = grant_q;
    assign o_busy      = (state_q == LOCK);

`ifdef FIFO_WR_ARB_CNT_EN
    logic [31:0] beat_cnt_q [NREQ];
    logic [31:0] beat_cnt_d [NREQ];

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            beat_cnt_d[k] = beat_cnt_q[k] + {31'd0, o_req_ready[k]};
        end
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NREQ; k++) begin
            if (i_rst) begin
                beat_cnt_q[k] <= '0;
            end else begin
                beat_cnt_q[k] <= beat_cnt_d[k];
            end
        end
    end

    always_comb begin
        o_beat_cnt = '0;
        for (int k = 0; k < NREQ; k++) begin
            o_beat_cnt[k*32 +: 32] = beat_cnt_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - randomized and directed bench for fifo_wr_arb against a behavioural model
module tb_fifo_wr_arb;

    localparam int NREQ      = 4;
    localparam int DW        = 32;
    localparam int DEPTH     = 1024;
    localparam int MAX_BURST = 16;
    localparam int FW        = $clog2(DEPTH) + 1;

    logic                i_clk;
    logic                i_rst;
    logic [NREQ-1:0]     i_req_valid;
    logic [NREQ-1:0]     i_req_last;
    logic [NREQ*DW-1:0]  i_req_data;
    logic [NREQ-1:0]     o_req_ready;
    logic                o_wr;
    logic [DW-1:0]       o_data;
    logic                i_full;
    logic [FW-1:0]       i_fill;
    logic [NREQ-1:0]     o_grant;
    logic                o_busy;
`ifdef FIFO_WR_ARB_CNT_EN
    logic [NREQ*32-1:0]  o_beat_cnt;
`endif

    fifo_wr_arb #(
        .NREQ      (NREQ),
        .DW        (DW),
        .DEPTH     (DEPTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .i_req_last  (i_req_last),
        .i_req_data  (i_req_data),
        .o_req_ready (o_req_ready),
        .o_wr        (o_wr),
        .o_data      (o_data),
        .i_full      (i_full),
        .i_fill      (i_fill),
        .o_grant     (o_grant),
        .o_busy      (o_busy)
`ifdef FIFO_WR_ARB_CNT_EN
        ,
        .o_beat_cnt  (o_beat_cnt)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Sources: per requester, words left to send, packet length and position in packet.
    int words_left [NREQ];
    int plen       [NREQ];
    int pos        [NREQ];
    int seq        [NREQ];
    bit gap_en;
    int rd_pct;
    bit force_rd;
    int fill;
    int max_fill;
    int n_1023;
    int bad_1023;
    logic [DW-1:0] wlog [$];

    // Reference model: owner index (-1 when free), pointer, beats in current grant.
    int          m_owner;
    int          m_ptr;
    int          m_beats;
    logic        m_wr;
    logic [DW-1:0] m_data;
    logic [31:0] m_cnt [NREQ];

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_beats = 0;
        m_wr    = 1'b0;
        m_data  = '0;
        for (int k = 0; k < NREQ; k++) m_cnt[k] = '0;
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < NREQ; k++) begin
            i_req_valid[k] = (words_left[k] > 0) && (!gap_en || $urandom_range(0, 3) != 0);
            i_req_last[k]  = (words_left[k] == 1) || (pos[k] == plen[k] - 1);
            i_req_data[k*DW +: DW] = {8'(k), 24'(seq[k])};
        end
        i_fill = FW'(fill);
        i_full = (fill == DEPTH);
    endtask

    task automatic model_step();
        logic [NREQ-1:0] er;
        logic [NREQ-1:0] eg;
        int g;
        int nb;
        int kk;
        bit space;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        check_eq("o_wr", 64'(o_wr), 64'(m_wr));
        check_eq("o_data", 64'(o_data), 64'(m_data));
        check_eq("o_grant", 64'(o_grant), 64'(eg));
        check_eq("o_busy", 64'(o_busy), 64'(m_owner >= 0));
        er = '0;
        g  = -1;
        if (!i_rst) begin
            space = !i_full && (int'(i_fill) + int'(m_wr) < DEPTH);
            if (space) begin
                if (m_owner >= 0) begin
                    if (i_req_valid[m_owner]) g = m_owner;
                end else begin
                    for (int j = 0; j < NREQ; j++) begin
                        kk = (m_ptr + j) % NREQ;
                        if (g < 0 && i_req_valid[kk]) g = kk;
                    end
                end
            end
        end
        if (g >= 0) er[g] = 1'b1;
        check_eq("o_req_ready", 64'(o_req_ready), 64'(er));
        if (i_rst) begin
            model_reset();
        end else if (g < 0) begin
            m_wr = 1'b0;
        end else begin
            m_wr     = 1'b1;
            m_data   = i_req_data[g*DW +: DW];
            m_cnt[g] = m_cnt[g] + 1;
            nb       = (m_owner < 0) ? 1 : m_beats + 1;
            if (i_req_last[g] || nb == MAX_BURST) begin
                m_owner = -1;
                m_beats = 0;
                m_ptr   = (g + 1) % NREQ;
            end else begin
                m_owner = g;
                m_beats = nb;
            end
        end
    endtask

    task automatic cycle();
        logic [NREQ-1:0] rdy_s, val_s, last_s;
        logic wr_s, rst_s;
        bit rd;
        @(negedge i_clk);
        model_step();
        if (int'(i_fill) == DEPTH - 1 && o_wr) begin
            n_1023++;
            if (o_req_ready != '0) bad_1023++;
        end
        rdy_s  = o_req_ready;
        val_s  = i_req_valid;
        last_s = i_req_last;
        wr_s   = o_wr;
        rst_s  = i_rst;
        if (wr_s) wlog.push_back(o_data);
        @(posedge i_clk);
        #1;
        rd   = force_rd || ($urandom_range(1, 100) <= rd_pct);
        fill = fill + int'(wr_s) - ((fill > 0 && rd) ? 1 : 0);
        if (fill > max_fill) max_fill = fill;
        for (int k = 0; k < NREQ; k++) begin
            if (rst_s) begin
                words_left[k] = 0;
                pos[k]        = 0;
            end else if (val_s[k] && rdy_s[k]) begin
                words_left[k]--;
                seq[k]++;
                pos[k] = last_s[k] ? 0 : pos[k] + 1;
            end
        end
        drive_inputs();
    endtask

    task automatic reset_dut();
        i_rst = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            words_left[k] = 0;
            pos[k]        = 0;
            plen[k]       = 1;
        end
        drive_inputs();
        cycle();
        cycle();
        i_rst = 1'b0;
        fill  = 0;
        drive_inputs();
        wlog.delete();
    endtask

    function automatic bit src_pending();
        for (int k = 0; k < NREQ; k++) if (words_left[k] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (src_pending() && n < max_cyc) begin
            cycle();
            n++;
        end
        if (n >= max_cyc) check_eq("drain_timeout", 64'(n), 64'(max_cyc - 1));
        cycle();
        cycle();
    endtask

    task automatic start_pkt(input int k, input int len, input int words);
        plen[k]       = len;
        words_left[k] = words;
        pos[k]        = 0;
        drive_inputs();
    endtask

    initial begin
        int base;
        int n;
        i_rst       = 1'b1;
        i_req_valid = '0;
        i_req_last  = '0;
        i_req_data  = '0;
        i_fill      = '0;
        i_full      = 1'b0;
        gap_en      = 1'b0;
        rd_pct      = 100;
        force_rd    = 1'b0;
        fill        = 0;
        max_fill    = 0;
        n_1023      = 0;
        bad_1023    = 0;
        for (int k = 0; k < NREQ; k++) seq[k] = 0;
        model_reset();
        reset_dut();

        // Three single-beat words from req0 in order
        base = seq[0];
        start_pkt(0, 1, 3);
        drain(40);
        check_eq("s1_count", 64'(wlog.size()), 64'd3);
        for (int i = 0; i < 3 && i < wlog.size(); i++)
            check_eq("s1_order", 64'(wlog[i]), 64'({8'd0, 24'(base + i)}));

        // All four with single-beat words: rotation 0,1,2,3,0
        reset_dut();
        for (int k = 0; k < NREQ; k++) start_pkt(k, 1, 2);
        drain(60);
        check_eq("s2_count", 64'(wlog.size()), 64'd8);
        for (int i = 0; i < 5 && i < wlog.size(); i++)
            check_eq("s2_rotate", 64'(wlog[i][31:24]), 64'(i % NREQ));

        // 20-beat packet from req2 is cut at MAX_BURST, req0 slips in, req2 resumes
        reset_dut();
        start_pkt(2, 20, 20);
        cycle();
        start_pkt(0, 1, 1);
        drain(100);
        check_eq("s3_count", 64'(wlog.size()), 64'd21);
        for (int i = 0; i < 21 && i < wlog.size(); i++)
            check_eq("s3_owner", 64'(wlog[i][31:24]), (i == 16) ? 64'd0 : 64'd2);

        // Fill the downstream FIFO to DEPTH with no reads, then free one slot
        reset_dut();
        rd_pct   = 0;
        max_fill = 0;
        start_pkt(1, 8, 2000);
        n = 0;
        while (fill < DEPTH && n < 1200) begin
            cycle();
            n++;
        end
        for (int i = 0; i < 4; i++) cycle();
        check_eq("s4_max_fill", 64'(max_fill), 64'(DEPTH));
        check_eq("s4_fill_full", 64'(fill), 64'(DEPTH));
        check_eq("s4_seen_1023", 64'(n_1023 > 0), 64'd1);
        check_eq("s4_ready_1023", 64'(bad_1023), 64'd0);
        force_rd = 1'b1;
        cycle();
        force_rd = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check_eq("s4_refill", 64'(fill), 64'(DEPTH));
        rd_pct = 100;

        // Reset in the middle of a locked 10-beat packet
        reset_dut();
        base = seq[3];
        start_pkt(3, 10, 10);
        n = 0;
        while (seq[3] - base < 5 && n < 50) begin
            cycle();
            n++;
        end
        check_eq("s5_five_beats", 64'(seq[3] - base), 64'd5);
        check_eq("s5_busy_before", 64'(o_busy), 64'd1);
        reset_dut();
        check_eq("s5_wr_after", 64'(o_wr), 64'd0);
        check_eq("s5_grant_after", 64'(o_grant), 64'd0);
        check_eq("s5_busy_after", 64'(o_busy), 64'd0);
        start_pkt(1, 1, 1);
        start_pkt(0, 1, 1);
        drain(40);
        check_eq("s5_count", 64'(wlog.size()), 64'd2);
        if (wlog.size() > 0) check_eq("s5_first_owner", 64'(wlog[0][31:24]), 64'd0);

`ifdef FIFO_WR_ARB_CNT_EN
        reset_dut();
        start_pkt(1, 7, 7);
        drain(40);
        for (int k = 0; k < NREQ; k++) begin
            check_eq("s6_beat_cnt", 64'(o_beat_cnt[k*32 +: 32]), (k == 1) ? 64'd7 : 64'd0);
            check_eq("s6_beat_cnt_model", 64'(o_beat_cnt[k*32 +: 32]), 64'(m_cnt[k]));
        end
`endif

        // Random traffic with gaps, varying read pressure and rare resets
        reset_dut();
        gap_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) begin
                case ((c / 500) % 4)
                    0: rd_pct = 100;
                    1: rd_pct = 50;
                    2: rd_pct = 2;
                    default: rd_pct = 30;
                endcase
            end
            for (int k = 0; k < NREQ; k++) begin
                if (words_left[k] == 0 && $urandom_range(0, 7) == 0) begin
                    plen[k]       = $urandom_range(1, 24);
                    words_left[k] = plen[k] * $urandom_range(1, 2);
                    pos[k]        = 0;
                end
            end
            i_rst = ($urandom_range(0, 799) == 0);
            drive_inputs();
            cycle();
        end
        i_rst = 1'b0;
        check_eq("rand_fill_bound", 64'(max_fill <= DEPTH), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
